// File: rtl/hex_scan_mux.sv
// Time-multiplexed driver for a common-segment 8-digit display with a
// frame-synchronous shadow copy of the patterns and a per-slot blanking gap.
// Optional brightness control is enabled by defining SCAN_DIM_EN.
module hex_scan_mux #(
  parameter int DIV       = 6250,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [55:0] hex_in,
`ifdef SCAN_DIM_EN
  input  logic [1:0]  dim,
`endif
  output logic [6:0]  seg_n,
  output logic [7:0]  dig_n,
  output logic [2:0]  digit_idx,
  output logic        frame_start
);

  localparam int              CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

`ifdef SCAN_DIM_EN
  localparam int W      = DIV - BLANK_CYC;
  localparam int LEN_00 = W;
  localparam int LEN_01 = (3 * W) >> 2;
  localparam int LEN_10 = W >> 1;
  localparam int LEN_11 = W >> 2;
`endif

  logic [CW-1:0] slot_cnt, cnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [55:0]   shadow, shadow_nx;
  logic          slot_end, load;
  logic          lit;
  logic [6:0]    seg_nx;
  logic [7:0]    dig_nx;
`ifdef SCAN_DIM_EN
  int            lit_len;
`endif

  // Outputs are computed from the next state so they line up with the
  // counters in the same cycle rather than lagging by one clock.
  always_comb begin
    slot_end  = (slot_cnt == LAST);
    load      = slot_end && (idx == 3'd7);
    cnt_nx    = slot_end ? '0 : slot_cnt + 1'b1;
    idx_nx    = slot_end ? idx + 3'd1 : idx;
    shadow_nx = load ? hex_in : shadow;

    lit = (int'(cnt_nx) >= BLANK_CYC);
`ifdef SCAN_DIM_EN
    case (dim)
      2'b00:   lit_len = LEN_00;
      2'b01:   lit_len = LEN_01;
      2'b10:   lit_len = LEN_10;
      default: lit_len = LEN_11;
    endcase
    lit = lit && (int'(cnt_nx) < BLANK_CYC + lit_len);
`endif

    seg_nx = 7'h7F;
    dig_nx = 8'hFF;
    if (lit) begin
      seg_nx = shadow_nx[int'(idx_nx) * 7 +: 7];
      dig_nx = ~(8'd1 << idx_nx);
    end
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      slot_cnt    <= '0;
      idx         <= 3'd0;
      // NOTE: the shadow store is reset explicitly; the first frame must
      // display blank rather than whatever the flops powered up with.
      shadow      <= '1;
      seg_n       <= 7'h7F;
      dig_n       <= 8'hFF;
      digit_idx   <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      slot_cnt    <= cnt_nx;
      idx         <= idx_nx;
      shadow      <= shadow_nx;
      seg_n       <= seg_nx;
      dig_n       <= dig_nx;
      digit_idx   <= idx_nx;
      frame_start <= load;
    end
  end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Scoreboard bench for hex_scan_mux (DIV=8, BLANK_CYC=2): a cycle-count
// reference model pushes expected outputs, a negedge monitor compares them.
module tb_hex_scan_mux;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        clr;
  logic [55:0] hex_in;
  logic [6:0]  seg_n;
  logic [7:0]  dig_n;
  logic [2:0]  digit_idx;
  logic        frame_start;
`ifdef SCAN_DIM_EN
  logic [1:0]  dim;
`endif

  hex_scan_mux #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk         (clk),
    .clr         (clr),
    .hex_in      (hex_in),
`ifdef SCAN_DIM_EN
    .dim         (dim),
`endif
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [7:0] dig;
    logic [2:0] idx;
    logic       fs;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n;          // clock edges since clr release
  logic [55:0] shadow_m;
  logic [1:0]  dim_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: position in the frame follows directly from the edge count.
  function automatic exp_t model(input int cyc, input logic [55:0] shd, input logic [1:0] dm);
    exp_t e;
    int slot, d, len;
    bit on;
    slot = cyc % DIV;
    d    = (cyc / DIV) % 8;
    on   = (slot >= BLANK);
`ifdef SCAN_DIM_EN
    case (dm)
      2'b00:   len = DIV - BLANK;
      2'b01:   len = (3 * (DIV - BLANK)) / 4;
      2'b10:   len = (DIV - BLANK) / 2;
      default: len = (DIV - BLANK) / 4;
    endcase
    on = on && ((slot - BLANK) < len);
`else
    len = 0;
    if (dm != 2'b00) len = 1;
`endif
    e.seg = on ? shd[7*d +: 7] : 7'h7F;
    e.dig = on ? ~(8'd1 << d) : 8'hFF;
    e.idx = 3'(d);
    e.fs  = (cyc > 0) && (cyc % FRAME == 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (clr) begin
      if (n % FRAME == FRAME - 1) shadow_m = hex_in;
`ifdef SCAN_DIM_EN
      dim_m = dim;
`endif
      n++;
    end
    #1;
    sb.push_back(model(n, shadow_m, dim_m));
  endtask

  task automatic set_hex(input int d, input logic [6:0] v);
    hex_in[7*d +: 7] = v;
  endtask

  // Asserted just after an edge; the already-queued prediction is replaced
  // because the outputs must go blank right away.
  task automatic do_reset(input int hold);
    clr = 1'b0;
    sb.delete();
    n        = 0;
    shadow_m = '1;
    sb.push_back(model(0, shadow_m, dim_m));
    #1;
    check("async_seg", 32'(seg_n), 32'h7F);
    check("async_dig", 32'(dig_n), 32'hFF);
    check("async_idx", 32'(digit_idx), 32'd0);
    check("async_fs",  32'(frame_start), 32'd0);
    repeat (hold) tick();
    #1 clr = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      check("onecold", 32'($countones(~dig_n) <= 1), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg_n",       32'(seg_n),       32'(e.seg));
        check("dig_n",       32'(dig_n),       32'(e.dig));
        check("digit_idx",   32'(digit_idx),   32'(e.idx));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clr      = 1'b0;
    hex_in   = '1;
    n        = 0;
    shadow_m = '1;
    dim_m    = 2'b00;
`ifdef SCAN_DIM_EN
    dim      = 2'b00;
`endif
    #12;
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dig", 32'(dig_n), 32'hFF);
    check("rst_fs",  32'(frame_start), 32'd0);
    repeat (3) tick();
    #1 clr = 1'b1;

    // Directed: HEX0=40, HEX1=79, then HEX0 changes mid-frame at idx 3.
    set_hex(0, 7'h40);
    set_hex(1, 7'h79);
    while (n < FRAME + 3 * DIV + 2) tick();
    set_hex(0, 7'h24);
    while (n < 2 * FRAME + 5 * DIV + 4) tick();
    do_reset(3);

    // First frame after the mid-run reset must be blank again.
    while (n < FRAME + 4) tick();

`ifdef SCAN_DIM_EN
    dim = 2'b10;
    while (n < 2 * FRAME + 4) tick();
    dim = 2'b11;
    while (n < 3 * FRAME + 4) tick();
`endif

    // Randomised run with sporadic pattern (and dim) changes and resets.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(7) == 0) set_hex(int'($urandom_range(7)), 7'($urandom));
`ifdef SCAN_DIM_EN
      if ($urandom_range(15) == 0) dim = 2'($urandom);
`endif
      if (k == 700) do_reset(2);
      else tick();
    end

    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
